soc_io_uart_tx: RTL and testbench

- Memory-mapped IO slave that sits directly downstream of the RV32I core's load/store path.
- Consumes word writes and reads that the core directs to the IO page.
- Drives the board LEDs and serialises bytes onto ftdi_txd as 8N1 UART frames.
- Has a small transmit FIFO so the core can issue back-to-back stores without polling between bytes.

---
 rtl/soc_io_uart_tx_if.sv | 10 +
 rtl/soc_io_uart_tx.sv | 98 +++++++++
 tb/tb_soc_io_uart_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/soc_io_uart_tx_if.sv
// soc_io_uart_tx_if: IO-page word bus between the core load/store path and the UART/LED slave
interface soc_io_uart_tx_if;
  logic [3:0]  io_wordaddr;
  logic        io_wr;
  logic [31:0] io_wdata;
  logic        io_rd;
  logic [31:0] io_rdata;
  modport master(output io_wordaddr, io_wr, io_wdata, io_rd, input io_rdata);
  modport slave(input io_wordaddr, io_wr, io_wdata, io_rd, output io_rdata);
endinterface

// File: rtl/soc_io_uart_tx.sv
// soc_io_uart_tx: IO-page slave with LED register and 8N1 UART transmitter behind a TX queue.
// Define IO_TX_FIFO_EN for a 2^FIFO_DEPTH_LOG2 deep FIFO; otherwise a single holding register.
module soc_io_uart_tx #(
  parameter int BAUD_DIV        = 217,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic            clk,
  input  logic            resetn,
  soc_io_uart_tx_if.slave io,
  output logic [7:0]      leds,
  output logic            ftdi_txd
);
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
`ifdef IO_TX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
`else
  localparam int DEPTH = 1;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [15:0] baud;
  logic [2:0] idx;
  logic [7:0] shift, head;
  logic ovf, empty, full, busy, pop, push_req, push_ok, push_drop, stat_rd, tick, txd_n;
  logic [31:0] rd_val;
  logic unused_wdata;
  assign unused_wdata = &{1'b0, io.io_wdata[31:8]};
  assign empty     = count == '0;
  assign full      = count == CW'(DEPTH);
  assign busy      = state != IDLE || !empty;
  assign tick      = baud == 16'd0;
  assign push_req  = io.io_wr && io.io_wordaddr == 4'd1;
  // a pop in the same cycle frees a slot, so a push while full still lands
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && !push_ok;
  assign stat_rd   = io.io_rd && io.io_wordaddr == 4'd2;
  assign rd_val    = io.io_wordaddr == 4'd0 ? {24'd0, leds} :
                     io.io_wordaddr == 4'd2 ? {29'd0, ovf, full, busy} : 32'd0;
`ifdef IO_TX_FIFO_EN
  logic [7:0] mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wp, rp;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= io.io_wdata[7:0];
  assign head = mem[rp];
`else
  logic [7:0] hold;
  always_ff @(posedge clk)
    if (push_ok) hold <= io.io_wdata[7:0];
  assign head = hold;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      leds        <= 8'd0;
      io.io_rdata <= 32'd0;
      ovf         <= 1'b0;
      count       <= '0;
    end else begin
      if (io.io_wr && io.io_wordaddr == 4'd0) leds <= io.io_wdata[7:0];
      if (io.io_rd) io.io_rdata <= rd_val;
      ovf   <= push_drop | (ovf & ~stat_rd);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (empty ? IDLE : START) :
              !tick         ? state :
              state == START ? DATA :
              state == DATA  ? (idx == 3'd7 ? STOP : DATA) : IDLE;
  always_comb begin
    pop   = state == IDLE && !empty;
    txd_n = state == START ? 1'b0 : state == DATA ? shift[idx] : 1'b1;
  end
  // line is registered from the current state, so it trails the FSM by one cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      baud     <= 16'd0;
      idx      <= 3'd0;
      shift    <= 8'd0;
      ftdi_txd <= 1'b1;
    end else begin
      baud     <= state == IDLE ? (pop ? BAUD_LAST : 16'd0) : tick ? BAUD_LAST : baud - 16'd1;
      idx      <= state != DATA ? 3'd0 : tick ? idx + 3'd1 : idx;
      if (pop) shift <= head;
      ftdi_txd <= txd_n;
    end
endmodule

// File: tb/tb_soc_io_uart_tx.sv
// tb_soc_io_uart_tx: directed bench with a cycle-timeline model of the queue, line and registers.
module tb_soc_io_uart_tx;
  localparam int B = 4;
`ifdef IO_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] leds;
  logic ftdi_txd;
  soc_io_uart_tx_if bus();
  soc_io_uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .resetn(resetn), .io(bus), .leds(leds), .ftdi_txd(ftdi_txd)
  );
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // model: a byte popped at edge P is on the line for edges P+1..P+10*B
  logic [7:0] q[$];
  logic [7:0] m_cur = 8'd0;
  logic [7:0] m_leds = 8'd0;
  logic [31:0] m_rdata = 32'd0;
  logic m_ovf = 1'b0;
  logic m_act, m_full, m_pop, m_set, m_clr;
  int n = 0;
  int pop_edge = -1;
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      q.delete();
      m_leds = 8'd0;
      m_rdata = 32'd0;
      m_ovf = 1'b0;
      pop_edge = -1;
    end else begin
      n++;
      m_act  = pop_edge >= 0 && n <= pop_edge + 10 * B;
      m_full = q.size() == DEPTH;
      m_pop  = !m_act && q.size() > 0;
      m_clr  = 1'b0;
      m_set  = 1'b0;
      if (bus.io_rd) begin
        m_rdata = bus.io_wordaddr == 4'd0 ? {24'd0, m_leds} :
                  bus.io_wordaddr == 4'd2 ? {29'd0, m_ovf, m_full, m_act || q.size() > 0} : 32'd0;
        m_clr = bus.io_wordaddr == 4'd2;
      end
      if (m_pop) begin
        m_cur = q.pop_front();
        pop_edge = n;
      end
      if (bus.io_wr && bus.io_wordaddr == 4'd0) m_leds = bus.io_wdata[7:0];
      if (bus.io_wr && bus.io_wordaddr == 4'd1) begin
        if (!m_full || m_pop) q.push_back(bus.io_wdata[7:0]);
        else m_set = 1'b1;
      end
      m_ovf = m_set || (m_ovf && !m_clr);
    end

  function automatic logic exp_txd();
    int k;
    if (pop_edge < 0 || n <= pop_edge || n > pop_edge + 10 * B) return 1'b1;
    k = (n - pop_edge - 1) / B;
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : m_cur[k-1];
  endfunction

  always @(negedge clk)
    if (resetn) begin
      check("txd", {31'd0, ftdi_txd}, {31'd0, exp_txd()});
      check("leds", {24'd0, leds}, {24'd0, m_leds});
      check("rdata", bus.io_rdata, m_rdata);
    end

  // independent line receiver sampling each bit in its middle
  logic [7:0] rx_q[$];
  logic [7:0] rx_b = 8'd0;
  int rx_t = -1;
  always @(negedge clk)
    if (!resetn) rx_t = -1;
    else if (rx_t < 0) begin
      if (!ftdi_txd) rx_t = 0;
    end else begin
      rx_t++;
      if (rx_t >= 6 && rx_t <= 34 && rx_t % 4 == 2) rx_b[(rx_t - 6) / 4] = ftdi_txd;
      if (rx_t == 38) begin
        check("rx_stop_bit", {31'd0, ftdi_txd}, 32'd1);
        rx_q.push_back(rx_b);
        rx_t = -1;
      end
    end

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.io_wordaddr = a;
    bus.io_wdata = d;
    bus.io_wr = 1'b1;
    @(negedge clk);
    bus.io_wr = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    bus.io_wordaddr = a;
    bus.io_rd = 1'b1;
    @(negedge clk);
    bus.io_rd = 1'b0;
    v = bus.io_rdata;
  endtask

  initial begin
    logic [31:0] v;
    logic [9:0] pat;
    logic [7:0] exp_rx[$];
    bus.io_wordaddr = 4'd0;
    bus.io_wdata = 32'd0;
    bus.io_wr = 1'b0;
    bus.io_rd = 1'b0;
    idle(3);
    check("reset_leds", {24'd0, leds}, 32'd0);
    check("reset_txd", {31'd0, ftdi_txd}, 32'd1);
    resetn = 1'b1;
    idle(2);
    rd(4'd2, v); check("reset_status", v, 32'd0);
    wr(4'd0, 32'h1A5); check("leds_write", {24'd0, leds}, 32'hA5);
    rd(4'd0, v); check("leds_read", v, 32'hA5);
    rd(4'd1, v); check("data_read_zero", v, 32'd0);
    wr(4'hF, 32'hFF);
    rd(4'hF, v); check("unmapped_read", v, 32'd0);
    check("unmapped_write_leds", {24'd0, leds}, 32'hA5);
    // single frame of 0x55: start, data LSB first, stop
    wr(4'd1, 32'h155);
    idle(1);
    check("pre_start_idle", {31'd0, ftdi_txd}, 32'd1);
    idle(1);
    pat = 10'b1_01010101_0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("frame_bit%0d", k), {31'd0, ftdi_txd}, {31'd0, pat[k]});
      if (k < 9) idle(B);
    end
    rd(4'd2, v); check("busy_in_stop", v, 32'd1);
    idle(2);
    rd(4'd2, v); check("busy_dropped", v, 32'd0);
    check("rx_single_count", rx_q.size(), 32'd1);
    check("rx_single_byte", {24'd0, rx_q[0]}, 32'h55);
    rx_q.delete();
    // burst of six back-to-back stores
    for (int i = 1; i <= 6; i++) begin
      bus.io_wordaddr = 4'd1;
      bus.io_wdata = 32'(i);
      bus.io_wr = 1'b1;
      @(negedge clk);
    end
    bus.io_wr = 1'b0;
    rd(4'd2, v); check("burst_status", v, 32'h7);
    rd(4'd2, v); check("burst_status_ovf_cleared", v, 32'h3);
    idle(6 * 44);
`ifdef IO_TX_FIFO_EN
    exp_rx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`else
    exp_rx = '{8'h01, 8'h02};
`endif
    check("burst_rx_count", rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
      check($sformatf("burst_rx_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
    rd(4'd2, v); check("burst_done_status", v, 32'd0);
    rx_q.delete();
    // reset in the middle of data bit 3 of 0xA3 (a zero bit)
    wr(4'd1, 32'hA3);
    idle(19);
    check("bit3_low", {31'd0, ftdi_txd}, 32'd0);
    #1 resetn = 1'b0;
    #1 check("async_reset_txd", {31'd0, ftdi_txd}, 32'd1);
    check("async_reset_leds", {24'd0, leds}, 32'd0);
    idle(2);
    resetn = 1'b1;
    idle(1);
    rd(4'd2, v); check("post_reset_status", v, 32'd0);
    idle(60);
    check("no_frame_txd", {31'd0, ftdi_txd}, 32'd1);
    check("no_frame_rx", rx_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
